// File: rtl/mem_io_sequencer_if.sv
// rtl/mem_io_sequencer_if.sv - CPU, loader, data-RAM and IO bus signals of the memory/IO sequencer
interface mem_io_sequencer_if #(
  parameter int ADDR_W = 14
);
  // CPU datapath side
  logic              cpu_mem_read;
  logic              cpu_mem_write;
  logic              cpu_io_read;
  logic              cpu_io_write;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  // UART program loader side
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_ready;
  // Synchronous data RAM
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  // Memory-mapped IO bus
  logic              io_req;
  logic              io_we;
  logic [9:0]        io_addr;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata;
  logic              io_ack;
  logic              io_err;

  // The sequencer
  modport master (
    input  cpu_mem_read, cpu_mem_write, cpu_io_read, cpu_io_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ld_valid, ld_addr, ld_wdata,
    output ld_ready,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output io_req, io_we, io_addr, io_wdata, io_err,
    input  io_rdata, io_ack
  );

  // Everything around the sequencer: CPU, loader, RAM and IO devices
  modport slave (
    output cpu_mem_read, cpu_mem_write, cpu_io_read, cpu_io_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ld_valid, ld_addr, ld_wdata,
    input  ld_ready,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  io_req, io_we, io_addr, io_wdata, io_err,
    output io_rdata, io_ack
  );
endinterface

// File: rtl/mem_io_sequencer.sv
// rtl/mem_io_sequencer.sv - data-side RAM/IO sequencer with CPU/loader round-robin RAM arbitration
module mem_io_sequencer #(
  parameter int ADDR_W     = 14,
  parameter int IO_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_io_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_RD  = 2'd1,
    IO_WAIT = 2'd2
  } state_t;

  // Last IO_WAIT cycle index; the timeout fires when the counter reaches it without an ack.
  localparam logic [7:0] CNT_LAST = 8'(IO_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_ld_q, last_ld_d;   // 1 = loader held the most recent RAM grant
  logic [7:0]        cnt_q;
  logic              io_req_q;
  logic              io_we_q;
  logic [9:0]        io_addr_q;
  logic [31:0]       io_wdata_q;

  logic              cpu_req;
  logic              grant_ld;
  logic              grant_cpu;
  logic              io_start;
  logic              io_done;
  logic              stall_c;
  logic              ld_ready_c;
  logic              ram_en_c;
  logic              ram_we_c;
  logic              io_err_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [31:0]       ram_wdata_c;
  logic [31:0]       rdata_c;

  assign cpu_req = bus.cpu_mem_read | bus.cpu_mem_write | bus.cpu_io_read | bus.cpu_io_write;

  // Arbitration, next-state decode and all combinational outputs
  always_comb begin
    state_d     = state_q;
    last_ld_d   = last_ld_q;
    grant_ld    = 1'b0;
    grant_cpu   = 1'b0;
    io_start    = 1'b0;
    io_done     = 1'b0;
    stall_c     = 1'b0;
    ld_ready_c  = 1'b0;
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    io_err_c    = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    rdata_c     = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req && bus.ld_valid) begin
          // Tie: whoever did not win last time gets the RAM.
          grant_cpu = last_ld_q;
          grant_ld  = ~last_ld_q;
        end else begin
          grant_cpu = cpu_req;
          grant_ld  = bus.ld_valid;
        end
        if (grant_ld) begin
          ram_en_c    = 1'b1;
          ram_we_c    = 1'b1;
          ram_addr_c  = bus.ld_addr;
          ram_wdata_c = bus.ld_wdata;
          ld_ready_c  = 1'b1;
          stall_c     = cpu_req;
          last_ld_d   = 1'b1;
        end else if (grant_cpu) begin
          last_ld_d   = 1'b0;
          ram_addr_c  = bus.cpu_addr[ADDR_W+1:2];
          ram_wdata_c = bus.cpu_wdata;
          if (bus.cpu_mem_write) begin
            ram_en_c = 1'b1;
            ram_we_c = 1'b1;
          end else if (bus.cpu_mem_read) begin
            ram_en_c = 1'b1;
            stall_c  = 1'b1;
            state_d  = RAM_RD;
          end else begin
            stall_c  = 1'b1;
            io_start = 1'b1;
            state_d  = IO_WAIT;
          end
        end
      end
      RAM_RD: begin
        rdata_c = bus.ram_rdata;
        state_d = IDLE;
      end
      IO_WAIT: begin
        if (bus.io_ack) begin
          rdata_c = io_we_q ? 32'd0 : bus.io_rdata;
          io_done = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // io_err is decoded from registered state/counter so it lands in the completion cycle;
          // a late ack in that same cycle still wins over the timeout.
          io_err_c = 1'b1;
          io_done  = 1'b1;
          state_d  = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant history, IO wait counter and the registered IO bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_ld_q  <= 1'b1;
      cnt_q      <= '0;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_ld_q <= last_ld_d;
      if (io_start) begin
        io_req_q   <= 1'b1;
        io_we_q    <= bus.cpu_io_write;
        io_addr_q  <= bus.cpu_addr[9:0];
        io_wdata_q <= bus.cpu_wdata;
        cnt_q      <= '0;
      end else if (io_done) begin
        io_req_q <= 1'b0;
      end else if (state_q == IO_WAIT) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign bus.cpu_stall = rst_n & stall_c;
  assign bus.ld_ready  = rst_n & ld_ready_c;
  assign bus.ram_en    = rst_n & ram_en_c;
  assign bus.ram_we    = rst_n & ram_we_c;
  assign bus.ram_addr  = rst_n ? ram_addr_c : '0;
  assign bus.ram_wdata = rst_n ? ram_wdata_c : 32'd0;
  assign bus.cpu_rdata = rst_n ? rdata_c : 32'd0;
  assign bus.io_err    = rst_n & io_err_c;
  assign bus.io_req    = io_req_q;
  assign bus.io_we     = io_we_q;
  assign bus.io_addr   = io_addr_q;
  assign bus.io_wdata  = io_wdata_q;

endmodule
